lsu_axi_lite_master: RTL and testbench

- Initiator side of the core's simplified AXI-lite memory bus: one read channel pair (ar/r) plus one combined write-address/data channel with a write response (w/b).
- Accepts one load/store request at a time from the memory stage and drives the bus. A load's returned doubleword is aligned and sign/zero-extended; a store's byte offset and size are encoded onto w_shifter/w_DWHB.
- Sits between the LSU pipeline stage and the SRAM/cache responder. A separate instance serves instruction fetch, with req_wen tied low.

---
 rtl/lsu_axi_lite_master.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_axi_lite_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_lite_master.sv
// Load/store unit bus initiator for the simplified AXI-lite memory bus.
// Takes one request at a time from the memory stage and drives either a read
// (ar/r) or a combined write (w/b) transaction. It returns an aligned and
// extended load result, or a store completion, together with the measured
// bus latency. Misaligned requests get an error response and never reach the bus.
module lsu_axi_lite_master #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LAT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  // pipeline request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  // pipeline response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [LAT_W-1:0]  resp_lat,
  // read channels
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  // write channels
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        w_shifter,
  output logic [7:0]        w_DWHB,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StW,
    StB,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [LAT_W-1:0]    rlat_q, rlat_d;

  logic                misaligned;
  logic [LAT_W-1:0]    lat_inc;
  logic [5:0]          rd_shamt;
  logic [5:0]          wr_shamt;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   wr_shifted;
  logic [DATA_W-1:0]   load_ext;

  // Alignment check on the live request fields (only consulted on accept).
  always_comb begin
    misaligned = 1'b0;
    unique case (req_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = req_addr[0];
      2'd2: misaligned = |req_addr[1:0];
      2'd3: misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Saturating increment of the latency counter.
  always_comb begin
    lat_inc = (&lat_q) ? lat_q : lat_q + LAT_W'(1);
  end

  // Store data is placed at its byte lane when the request is accepted.
  always_comb begin
    wr_shamt   = {req_addr[2:0], 3'b000};
    wr_shifted = req_wdata << wr_shamt;
  end

  // Load result: move the addressed bytes down to bit 0, then truncate and extend.
  always_comb begin
    rd_shamt   = {addr_q[2:0], 3'b000};
    rd_shifted = rdata >> rd_shamt;
    load_ext   = rd_shifted;
    unique case (size_q)
      2'd0: load_ext = unsigned_q ? {56'b0, rd_shifted[7:0]}
                                  : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {48'b0, rd_shifted[15:0]}
                                  : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: load_ext = unsigned_q ? {32'b0, rd_shifted[31:0]}
                                  : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      2'd3: load_ext = rd_shifted;
      default: load_ext = rd_shifted;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rlat_d     = rlat_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = wr_shifted;
          lat_d      = '0;
          if (misaligned) begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
            rlat_d  = '0;
          end else if (req_wen) begin
            state_d = StW;
          end else begin
            state_d = StAr;
          end
        end
      end
      StAr: begin
        lat_d = lat_inc;
        if (arready) begin
          state_d = StR;
        end
      end
      StR: begin
        lat_d = lat_inc;
        if (rvalid) begin
          state_d = StResp;
          rdata_d = load_ext;
          err_d   = 1'b0;
          // Includes the current cycle, so the fastest load reports 2.
          rlat_d  = lat_inc;
        end
      end
      StW: begin
        lat_d = lat_inc;
        if (wready) begin
          state_d = StB;
        end
      end
      StB: begin
        lat_d = lat_inc;
        if (bvalid) begin
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b0;
          rlat_d  = lat_inc;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      lat_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rlat_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rlat_q     <= rlat_d;
    end
  end

  // One-hot access size for the responder's byte-enable logic.
  always_comb begin
    w_DWHB = 8'h00;
    unique case (size_q)
      2'd0: w_DWHB = 8'h01;
      2'd1: w_DWHB = 8'h02;
      2'd2: w_DWHB = 8'h04;
      2'd3: w_DWHB = 8'h08;
      default: w_DWHB = 8'h00;
    endcase
  end

  // Bus and pipeline outputs come straight from state and registers.
  assign req_ready  = (state_q == StIdle);
  assign arvalid    = (state_q == StAr);
  assign rready     = (state_q == StR);
  assign wvalid     = (state_q == StW);
  assign bready     = (state_q == StB);
  assign resp_valid = (state_q == StResp);
  assign araddr     = addr_q;
  assign waddr      = addr_q;
  assign wdata      = wdata_q;
  assign w_shifter  = {5'b00000, addr_q[2:0]};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign resp_lat   = rlat_q;

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Directed bench for lsu_axi_lite_master; the bench plays the bus responder.
module tb_lsu_axi_lite_master;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [15:0] resp_lat;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  w_shifter;
  logic [7:0]  w_DWHB;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  lsu_axi_lite_master #(
    .ADDR_W(64),
    .DATA_W(64),
    .LAT_W (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .resp_lat    (resp_lat),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rready      (rready),
    .waddr       (waddr),
    .wdata       (wdata),
    .w_shifter   (w_shifter),
    .w_DWHB      (w_DWHB),
    .wvalid      (wvalid),
    .wready      (wready),
    .bvalid      (bvalid),
    .bready      (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    tick();
    // Scramble the request fields to show they were registered on accept.
    req_valid    = 1'b0;
    req_addr     = 64'hDEAD_BEEF_DEAD_BEEF;
    req_size     = 2'd0;
    req_unsigned = ~uns;
    req_wdata    = 64'h0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq({tag, ".idle_req_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, ".idle_resp_valid"}, 64'(resp_valid), 64'd0);
    check_eq({tag, ".idle_quiet"}, 64'({arvalid, rready, wvalid, bready}), 64'd0);
  endtask

  // Minimum-latency load with responder ready on the first sampled cycle.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] bus_data, input logic [63:0] exp);
    arready = 1'b1;
    issue(1'b0, addr, size, uns, 64'h0);
    check_eq({tag, ".arvalid"}, 64'(arvalid), 64'd1);
    check_eq({tag, ".araddr"}, araddr, addr);
    check_eq({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
    rvalid = 1'b1;
    rdata  = bus_data;
    tick();
    arready = 1'b0;
    check_eq({tag, ".rready"}, 64'({arvalid, rready}), 64'b01);
    tick();
    rvalid = 1'b0;
    rdata  = 64'h0;
    check_eq({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
    check_eq({tag, ".resp_rdata"}, resp_rdata, exp);
    check_eq({tag, ".resp_err"}, 64'(resp_err), 64'd0);
    check_eq({tag, ".resp_lat"}, 64'(resp_lat), 64'd2);
    finish_resp(tag);
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst.req_ready", 64'(req_ready), 64'd1);
    check_eq("rst.valids", 64'({arvalid, rready, wvalid, bready, resp_valid, resp_err}), 64'd0);
    check_eq("rst.resp_rdata", resp_rdata, 64'd0);
    check_eq("rst.resp_lat", 64'(resp_lat), 64'd0);
    check_eq("rst.araddr", araddr, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Loads: dword, signed/unsigned byte, word and half extraction
    do_load("ld_d", 64'h8000_0008, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
    do_load("ld_bs", 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("ld_bu", 64'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080);
    do_load("ld_ws", 64'h8000_0004, 2'd2, 1'b0, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
    do_load("ld_hu", 64'h8000_0002, 2'd1, 1'b1, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
    do_load("ld_hs", 64'h8000_0006, 2'd1, 1'b0, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_7FFF);

    // Store half with write backpressure then a delayed write response
    wready = 1'b0;
    bvalid = 1'b0;
    issue(1'b1, 64'h8000_0006, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      check_eq("st.wvalid", 64'(wvalid), 64'd1);
      check_eq("st.arvalid", 64'(arvalid), 64'd0);
      check_eq("st.waddr", waddr, 64'h8000_0006);
      check_eq("st.wdata", wdata, 64'hBEEF_0000_0000_0000);
      check_eq("st.w_shifter", 64'(w_shifter), 64'h06);
      check_eq("st.w_DWHB", 64'(w_DWHB), 64'h02);
      tick();
    end
    check_eq("st.wvalid_held", 64'(wvalid), 64'd1);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check_eq("st.b_phase", 64'({wvalid, bready}), 64'b01);
    tick();
    tick();
    check_eq("st.b_wait", 64'({bready, resp_valid}), 64'b10);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check_eq("st.resp_valid", 64'(resp_valid), 64'd1);
    check_eq("st.resp_lat", 64'(resp_lat), 64'd7);
    check_eq("st.resp_rdata", resp_rdata, 64'd0);
    check_eq("st.resp_err", 64'(resp_err), 64'd0);
    finish_resp("st");

    // Misaligned word load: immediate error, response held under backpressure
    arready = 1'b1;
    issue(1'b0, 64'h8000_0002, 2'd2, 1'b0, 64'h0);
    arready = 1'b0;
    check_eq("mis.resp_valid", 64'(resp_valid), 64'd1);
    check_eq("mis.resp_err", 64'(resp_err), 64'd1);
    check_eq("mis.resp_rdata", resp_rdata, 64'd0);
    check_eq("mis.resp_lat", 64'(resp_lat), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("mis.hold", 64'({resp_valid, resp_err, req_ready, arvalid}), 64'b1100);
    end
    finish_resp("mis");

    // Misaligned dword store never raises wvalid
    wready = 1'b1;
    issue(1'b1, 64'h8000_0004, 2'd3, 1'b0, 64'h1234);
    wready = 1'b0;
    check_eq("mis_st.flags", 64'({resp_valid, resp_err, wvalid}), 64'b110);
    finish_resp("mis_st");

    // Spurious responses in IDLE are ignored
    rvalid = 1'b1;
    bvalid = 1'b1;
    rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    check_eq("spur_idle", 64'({req_ready, resp_valid, rready, bready}), 64'b1000);
    rvalid = 1'b0;
    bvalid = 1'b0;

    // Load with arready delayed and a spurious bvalid during R
    arready = 1'b0;
    issue(1'b0, 64'h8000_0010, 2'd3, 1'b0, 64'h0);
    tick();
    check_eq("ar_hold.arvalid", 64'(arvalid), 64'd1);
    check_eq("ar_hold.araddr", araddr, 64'h8000_0010);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    bvalid = 1'b1;
    tick();
    tick();
    check_eq("spur_r", 64'({rready, bready, resp_valid}), 64'b100);
    bvalid = 1'b0;
    rvalid = 1'b1;
    rdata  = 64'h0102_0304_0506_0708;
    tick();
    rvalid = 1'b0;
    check_eq("ar_hold.resp_rdata", resp_rdata, 64'h0102_0304_0506_0708);
    check_eq("ar_hold.resp_lat", 64'(resp_lat), 64'd5);
    finish_resp("ar_hold");

    // Asynchronous reset while a write is pending
    wready = 1'b0;
    issue(1'b1, 64'h8000_0020, 2'd3, 1'b0, 64'hCAFE);
    check_eq("arst.wvalid_before", 64'(wvalid), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("arst.wvalid_drop", 64'(wvalid), 64'd0);
    check_eq("arst.req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check_eq("arst.after", 64'({req_ready, resp_valid, wvalid}), 64'b100);

    // Normal operation resumes after reset
    do_load("post_rst", 64'h8000_0001, 2'd0, 1'b1, 64'h0000_0000_0000_AB00, 64'h0000_0000_0000_00AB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
